// File: rtl/fifo_mux_rr_ctrl.sv
// Round-robin arbiter/sequencer sharing one 8:1 FIFO output mux among eight requesters.
// Drives the mux select, a valid/ready handshake on the muxed word, and a one-hot grant per accepted word.
module fifo_mux_rr_ctrl #(
  parameter int bw = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] gnt
);

  if (bw < 1) begin : g_bw_chk
    $error("bw must be at least 1");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] ptr_q, ptr_d;

  logic       xfer;
  logic [7:0] sel_oh;
  logic [3:0] pick_idle;
  logic [3:0] pick_next;

  // Returns {hit, index} of the first set bit of r searching start, start+1, ... mod 8.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    sel_oh    = 8'b0000_0001 << sel_q;
    xfer      = (state_q == S_BUSY) && out_ready;
    pick_idle = rr_pick(req, ptr_q);
    // The word just accepted is masked so other requesters get a turn.
    pick_next = rr_pick(req & ~sel_oh, sel_q + 3'd1);

    case (state_q)
      S_IDLE: begin
        if (pick_idle[3]) begin
          sel_d   = pick_idle[2:0];
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (xfer) begin
          ptr_d = sel_q + 3'd1;
          if (pick_next[3]) begin
            sel_d = pick_next[2:0];
          end else begin
            state_d = S_IDLE;
          end
        end else if (!req[sel_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sel_q   <= 3'd0;
      ptr_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  assign sel       = sel_q;
  assign out_valid = (state_q == S_BUSY);
  assign gnt       = xfer ? sel_oh : 8'h00;

endmodule

// File: tb/tb_fifo_mux_rr_ctrl.sv
// Directed bench for fifo_mux_rr_ctrl: streaming, full round-robin, wrap, stall, abort and async reset.
module tb_fifo_mux_rr_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [2:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] gnt;

  int n_checks = 0;
  int n_errors = 0;

  fifo_mux_rr_ctrl #(.bw(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gnt       (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req       = 8'h00;
    out_ready = 1'b0;
    step();
    step();
    check("rst_sel",   32'(sel),       32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_gnt",   32'(gnt),       32'h00);
    reset = 1'b0;

    // Lone streaming requester: one word every two cycles.
    req       = 8'h01;
    out_ready = 1'b1;
    step();
    check("lone_sel",    32'(sel),       32'd0);
    check("lone_valid",  32'(out_valid), 32'd1);
    check("lone_gnt",    32'(gnt),       32'h01);
    step();
    check("lone_bubble_valid", 32'(out_valid), 32'd0);
    check("lone_bubble_gnt",   32'(gnt),       32'h00);
    step();
    check("lone_valid2", 32'(out_valid), 32'd1);
    check("lone_gnt2",   32'(gnt),       32'h01);

    // All requesting: sel walks 0..7,0 back to back.
    apply_reset();
    req = 8'hFF;
    step();
    check("ff_sel0",   32'(sel),       32'd0);
    check("ff_valid0", 32'(out_valid), 32'd1);
    check("ff_gnt0",   32'(gnt),       32'h01);
    for (int k = 1; k <= 8; k++) begin
      step();
      check("ff_sel",   32'(sel),       32'(k % 8));
      check("ff_valid", 32'(out_valid), 32'd1);
      check("ff_gnt",   32'(gnt),       32'(8'h01 << (k % 8)));
    end

    // Consumer stall: sel/valid frozen, no grant.
    out_ready = 1'b0;
    #1;
    check("stall_gnt_now", 32'(gnt), 32'h00);
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_sel",   32'(sel),       32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_gnt",   32'(gnt),       32'h00);
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_gnt", 32'(gnt), 32'h01);
    step();
    out_ready = 1'b0;
    #1;
    check("stall_adv_sel", 32'(sel),       32'd1);
    check("stall_adv_gnt", 32'(gnt),       32'h00);
    check("stall_adv_vld", 32'(out_valid), 32'd1);

    // Wrap-around: after grant to 2, ptr=3, req 7 and 2 give 7 then 2.
    apply_reset();
    req       = 8'h04;
    out_ready = 1'b1;
    step();
    check("wrap_sel2", 32'(sel), 32'd2);
    check("wrap_gnt2", 32'(gnt), 32'h04);
    req = 8'h84;
    step();
    check("wrap_sel7", 32'(sel), 32'd7);
    check("wrap_gnt7", 32'(gnt), 32'h80);
    step();
    check("wrap_sel2b",  32'(sel),       32'd2);
    check("wrap_gnt2b",  32'(gnt),       32'h04);
    check("wrap_valid",  32'(out_valid), 32'd1);

    // Abort: granted requester 2 withdraws before ready; ptr must stay at 0.
    out_ready = 1'b0;
    req       = 8'h80;
    #1;
    check("abort_gnt_now", 32'(gnt), 32'h00);
    step();
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_gnt",   32'(gnt),       32'h00);
    check("abort_sel",   32'(sel),       32'd2);
    req = 8'h84;
    step();
    check("rereq_sel",   32'(sel),       32'd2);
    check("rereq_valid", 32'(out_valid), 32'd1);

    // Asynchronous reset in the middle of a transfer.
    out_ready = 1'b1;
    #1;
    check("pre_rst_gnt", 32'(gnt), 32'h04);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sel",   32'(sel),       32'd0);
    check("mid_rst_gnt",   32'(gnt),       32'h00);
    reset = 1'b0;
    req   = 8'h30;
    step();
    check("post_rst_sel",   32'(sel),       32'd4);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_gnt",   32'(gnt),       32'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_mux_rr_ctrl.md
# fifo_mux_rr_ctrl

Round-robin arbiter and sequencer for the 8:1 FIFO output mux: it shares a single `fifo_mux_8_1` datapath among eight requesters. It drives the mux `sel`, presents a valid/ready handshake on the muxed output, and returns a per-requester grant pulse on each accepted word. It sits between the eight requester FIFOs (their `req` flags and data feeding the mux inputs) and the downstream consumer of the mux `out`.

## Interface
- `bw`, default 4: data width of the associated mux. Informational only; the controller carries no data.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `req` input 8: `req[i]` high means requester i has a word on mux input `in<i>`.
- `sel` output 3: mux select (registered); wire to `fifo_mux_8_1.sel`.
- `out_valid` output 1: mux `out` holds a valid word from requester `sel` (registered).
- `out_ready` input 1: consumer accepts the word when `out_valid & out_ready`.
- `gnt` output 8: one-hot acknowledge, `gnt[sel] = out_valid & out_ready`. Combinational from state and `out_ready`; the requester pops/advances on it.

## Operation
- States:
  - IDLE: `out_valid=0`.
  - BUSY: `out_valid=1`, `sel` frozen.
- Pointer `ptr[2:0]` is the highest-priority index. Search order is `ptr, ptr+1, … ptr+7`, wrapping mod 8.
- IDLE, `req != 0`: `sel <= first set index in search order`, go to BUSY. If `req == 0`, stay in IDLE; `sel` holds its last value.
- BUSY with transfer (`out_valid & out_ready`):
  - `ptr <= sel+1` (mod 8).
  - Re-arbitrate on `req & ~onehot(sel)`, searching from `sel+1`.
  - Hit: load new `sel`, stay in BUSY (back-to-back transfer, no bubble).
  - Miss: go to IDLE.
- BUSY without transfer:
  - If `req[sel]=1`, hold.
  - If `req[sel]=0` (requester withdrew), abort: go to IDLE. `ptr` is unchanged and no `gnt` is issued.
- Requester rule: hold `req` and data stable until `gnt[i]`. After `gnt[i]`, `req[i]` may stay high for the next word.
- A lone requester streaming continuously gets one word every 2 cycles, because its own request is masked in the transfer cycle.
- Fairness: any continuously requesting index is served within 8 transfers.
- `gnt` is never asserted in IDLE. At most one bit of `gnt` is set.
- `out_valid` never drops without a transfer unless `req[sel]` drops (the abort case).
- Reset values: state IDLE, `sel=0`, `ptr=0`, `out_valid=0`, `gnt=0`.
  - Reset asserted mid-transfer clears everything immediately.
  - The first grant after reset searches from index 0.

## Timing
- Request to valid: `req` sampled high at edge t (in IDLE) gives `out_valid=1` and `sel` valid after edge t.
- The mux output is valid in that same cycle, since the mux is combinational.
- Transfer cycle: `gnt[sel]` is high in the cycle where `out_valid & out_ready`. The next `sel`/`out_valid` take effect after that edge.
- Abort: the withdrawal is seen at edge t, and `out_valid=0` after edge t.
- `out_ready` may toggle freely. `sel` never changes while `out_valid=1` and no transfer has occurred.
- Critical path: 8-bit rotate plus priority encode plus 3-bit register; no multi-cycle paths.

## Test plan
- Reset, then `req=8'b0000_0001` with `out_ready=1`:
  - Cycle 1: `sel=0`, `out_valid=1`, `gnt=8'h01`.
  - Next cycle: `out_valid=0`.
  - Transfers repeat every 2 cycles.
- `req=8'hFF` held with `out_ready=1`:
  - `sel` sequence is 0,1,2,…,7,0 on consecutive cycles.
  - `out_valid` stays 1 with no bubbles.
  - `gnt` walks one-hot from `8'h01` to `8'h80`.
- `req=8'b1000_0100`, `ptr=3` (after a grant to index 2):
  - Next `sel=7`, then `sel=2`. Wrap-around is correct.
- `out_ready=0` for 5 cycles with `req=8'hFF`:
  - `sel` and `out_valid` are stable and `gnt=0` throughout.
  - On `out_ready=1`: exactly one `gnt` pulse, then `sel` advances.
- Granted requester drops `req` before `out_ready`:
  - `out_valid=0` the next cycle, no `gnt`, `ptr` unchanged.
  - Re-requesting wins again if it is the highest priority.
- Assert `reset` mid-BUSY with `out_valid=1`:
  - Outputs clear asynchronously (`out_valid=0`, `sel=0`, `gnt=0`).
  - After release, `req=8'h30` gives `sel=4`.
